// File: rtl/cam_multi_pkg.sv
// Shared op-code encoding for the multi-entry CAM and its helpers.
package cam_multi_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_INSERT = 2'b01,
        OP_DELETE = 2'b10,
        OP_CLEAR  = 2'b11
    } cam_op_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-set-bit priority encoder: idx is the smallest i with req[i] set, 0 if none.
module cam_prio_enc #(
    parameter  int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/cam_multi.sv
// Content-addressable tag store with auto-allocation, delete and clear,
// behind a valid/ready command channel and a single registered response stage.
module cam_multi
    import cam_multi_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 16,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic              rsp_err,
    output logic              full,
    output logic [IDX_W:0]    count
);

    logic [DATA_W-1:0] keys [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  match;
    logic [DEPTH-1:0]  free;
    logic [IDX_W-1:0]  match_idx;
    logic [IDX_W-1:0]  free_idx;
    logic              match_any;
    logic              free_any;
    logic              accept;
    cam_op_e           op;

    logic              nxt_hit;
    logic              nxt_err;
    logic [IDX_W-1:0]  nxt_idx;
    logic [DEPTH-1:0]  nxt_valid;
    logic [IDX_W:0]    nxt_count;
    logic              write_en;

    assign op        = cam_op_e'(cmd_op);
    assign cmd_ready = !rsp_valid || rsp_ready;
    assign accept    = cmd_valid && cmd_ready && !rst;
    assign free      = ~valid;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (keys[i] == cmd_data);
        end
    end

    cam_prio_enc #(.N(DEPTH)) u_match_enc (
        .req (match),
        .idx (match_idx),
        .any (match_any)
    );

    cam_prio_enc #(.N(DEPTH)) u_free_enc (
        .req (free),
        .idx (free_idx),
        .any (free_any)
    );

    // Response fields and the post-command table state, from pre-update state.
    always_comb begin
        nxt_hit   = 1'b0;
        nxt_err   = 1'b0;
        nxt_idx   = '0;
        nxt_valid = valid;
        nxt_count = count;
        write_en  = 1'b0;
        case (op)
            OP_LOOKUP: begin
                if (match_any) begin
                    nxt_hit = 1'b1;
                    nxt_idx = match_idx;
                end
            end
            OP_INSERT: begin
                if (match_any) begin
                    nxt_hit = 1'b1;
                    nxt_idx = match_idx;
                end else if (!full && free_any) begin
                    write_en            = 1'b1;
                    nxt_idx             = free_idx;
                    nxt_valid[free_idx] = 1'b1;
                    nxt_count           = count + 1'b1;
                end else begin
                    nxt_err = 1'b1;
                end
            end
            OP_DELETE: begin
                if (match_any) begin
                    nxt_hit              = 1'b1;
                    nxt_idx              = match_idx;
                    nxt_valid[match_idx] = 1'b0;
                    nxt_count            = count - 1'b1;
                end else begin
                    nxt_err = 1'b1;
                end
            end
            OP_CLEAR: begin
                nxt_valid = '0;
                nxt_count = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            count     <= '0;
            full      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_idx   <= '0;
            rsp_err   <= 1'b0;
        end else if (accept) begin
            valid     <= nxt_valid;
            count     <= nxt_count;
            full      <= (nxt_count == (IDX_W + 1)'(DEPTH));
            rsp_valid <= 1'b1;
            rsp_hit   <= nxt_hit;
            rsp_idx   <= nxt_idx;
            rsp_err   <= nxt_err;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Key storage carries no reset; an entry is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (accept && write_en) begin
            keys[free_idx] <= cmd_data;
        end
    end

endmodule

// File: tb/tb_cam_multi.sv
// Self-checking bench for cam_multi: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a table-level reference model.
module tb_cam_multi;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [IDX_W-1:0]  rsp_idx;
    logic              rsp_err;
    logic              full;
    logic [IDX_W:0]    count;

    int vectors     = 0;
    int miscompares = 0;

    bit               m_valid [DEPTH];
    logic [7:0]       m_key   [DEPTH];
    bit               armed   = 0;
    bit               e_valid = 0;
    bit               e_hit   = 0;
    bit               e_err   = 0;
    logic [IDX_W-1:0] e_idx   = '0;

    cam_multi #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hit   (rsp_hit),
        .rsp_idx   (rsp_idx),
        .rsp_err   (rsp_err),
        .full      (full),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic int findKey(input logic [7:0] k);
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_key[i] == k) return i;
        end
        return -1;
    endfunction

    function automatic int numValid();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
        return n;
    endfunction

    task automatic modelCommand(input logic [1:0] op, input logic [7:0] d);
        int f = findKey(d);
        e_hit = 0;
        e_err = 0;
        e_idx = '0;
        case (op)
            2'd0: if (f >= 0) begin e_hit = 1; e_idx = 4'(f); end
            2'd1: begin
                if (f >= 0) begin
                    e_hit = 1;
                    e_idx = 4'(f);
                end else if (numValid() < DEPTH) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (!m_valid[j]) begin
                            m_valid[j] = 1;
                            m_key[j]   = d;
                            e_idx      = 4'(j);
                            break;
                        end
                    end
                end else begin
                    e_err = 1;
                end
            end
            2'd2: begin
                if (f >= 0) begin
                    e_hit = 1;
                    e_idx = 4'(f);
                    m_valid[f] = 0;
                end else begin
                    e_err = 1;
                end
            end
            default: for (int j = 0; j < DEPTH; j++) m_valid[j] = 0;
        endcase
    endtask

    // Reference model advances on every rising edge from the inputs seen there.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
                e_valid = 0;
                armed   = 1;
            end else if (armed) begin
                if (cmd_valid && (!e_valid || rsp_ready)) begin
                    modelCommand(cmd_op, cmd_data);
                    e_valid = 1;
                end else if (rsp_ready) begin
                    e_valid = 0;
                end
            end
        end
    end

    // Every cycle: handshake/status against the model, response fields whenever one is owed.
    initial begin
        logic [7:0] act_s, exp_s;
        logic [5:0] act_r, exp_r;
        forever begin
            @(negedge clk);
            if (armed) begin
                exp_s = {(!e_valid || rsp_ready), e_valid, 5'(numValid()), (numValid() == DEPTH)};
                act_s = {cmd_ready, rsp_valid, count, full};
                vectors++;
                if (act_s !== exp_s) begin
                    miscompares++;
                    $display("[TB] FAIL status t=%0t got rdy/rv/cnt/full=%b want %b", $time, act_s, exp_s);
                end
                if (e_valid) begin
                    exp_r = {e_hit, e_idx, e_err};
                    act_r = {rsp_hit, rsp_idx, rsp_err};
                    vectors++;
                    if (act_r !== exp_r) begin
                        miscompares++;
                        $display("[TB] FAIL response t=%0t got hit/idx/err=%b want %b", $time, act_r, exp_r);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input bit rv, input bit hit,
                               input int idx, input bit err, input int cnt, input bit fl);
        logic [12:0] act, exp;
        act = {rsp_valid, rsp_hit, rsp_idx, rsp_err, count, full};
        exp = {rv, hit, 4'(idx), err, 5'(cnt), fl};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s got rv/hit/idx/err/cnt/full=%b want %b", name, act, exp);
        end
    endtask

    task automatic checkReady(input string name, input bit want);
        vectors++;
        if (cmd_ready !== want) begin
            miscompares++;
            $display("[TB] FAIL %s cmd_ready got %b want %b", name, cmd_ready, want);
        end
    endtask

    // Present one command, hold it until accepted (bounded), return just after the accepting edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] d);
        bit acc;
        int waited = 0;
        cmd_valid = 1;
        cmd_op    = op;
        cmd_data  = d;
        forever begin
            @(negedge clk);
            acc = cmd_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 20) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL accept_timeout op=%0d data=%h got no acceptance want acceptance", op, d);
                break;
            end
        end
        cmd_valid = 0;
    endtask

    task automatic idleCycle();
        cmd_valid = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1;
        cmd_valid = 0;
        cmd_op    = 2'd0;
        cmd_data  = '0;
        rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        checkOutput("reset_state", 0, 0, 0, 0, 0, 0);

        applyStimulus(2'd0, 8'h00); checkOutput("lookup_after_reset", 1, 0, 0, 0, 0, 0);
        applyStimulus(2'd1, 8'hA5); checkOutput("insert_a5", 1, 0, 0, 0, 1, 0);
        applyStimulus(2'd1, 8'h3C); checkOutput("insert_3c", 1, 0, 1, 0, 2, 0);
        applyStimulus(2'd1, 8'h7E); checkOutput("insert_7e", 1, 0, 2, 0, 3, 0);
        applyStimulus(2'd0, 8'h3C); checkOutput("lookup_3c", 1, 1, 1, 0, 3, 0);
        applyStimulus(2'd1, 8'hA5); checkOutput("insert_dup_a5", 1, 1, 0, 0, 3, 0);
        applyStimulus(2'd2, 8'h3C); checkOutput("delete_3c", 1, 1, 1, 0, 2, 0);
        applyStimulus(2'd1, 8'h11); checkOutput("insert_11_reuse", 1, 0, 1, 0, 3, 0);
        for (int i = 3; i < DEPTH; i++) begin
            applyStimulus(2'd1, 8'(8'h80 + i));
            checkOutput("fill", 1, 0, i, 0, i + 1, (i == DEPTH - 1));
        end
        applyStimulus(2'd1, 8'h99); checkOutput("insert_full", 1, 0, 0, 1, 16, 1);
        applyStimulus(2'd2, 8'h42); checkOutput("delete_miss", 1, 0, 0, 1, 16, 1);
        applyStimulus(2'd3, 8'h00); checkOutput("clear", 1, 0, 0, 0, 0, 0);
        applyStimulus(2'd0, 8'hA5); checkOutput("lookup_after_clear", 1, 0, 0, 0, 0, 0);

        // Backpressure: response must hold and the channel must stall.
        applyStimulus(2'd1, 8'h42); checkOutput("insert_42", 1, 0, 0, 0, 1, 0);
        idleCycle();
        rsp_ready = 0;
        applyStimulus(2'd0, 8'h42); checkOutput("stall_lookup", 1, 1, 0, 0, 1, 0);
        cmd_valid = 1;
        cmd_op    = 2'd1;
        cmd_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkReady("stall_ready", 0);
            checkOutput("stall_hold", 1, 1, 0, 0, 1, 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1;
        @(negedge clk);
        checkReady("release_ready", 1);
        @(posedge clk);
        #1;
        cmd_valid = 0;
        checkOutput("release_accept", 1, 0, 1, 0, 2, 0);

        // Reset with a response pending.
        idleCycle();
        rsp_ready = 0;
        applyStimulus(2'd1, 8'h66); checkOutput("pending_insert", 1, 0, 2, 0, 3, 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        rsp_ready = 1;
        checkOutput("reset_pending", 0, 0, 0, 0, 0, 0);
        applyStimulus(2'd0, 8'h66); checkOutput("lookup_after_rst", 1, 0, 0, 0, 0, 0);

        // Randomized traffic over a small key space so the table fills and drains.
        for (int c = 0; c < 3000; c++) begin
            int r = int'($urandom_range(0, 99));
            @(posedge clk);
            #1;
            rst       = ($urandom_range(0, 249) == 0);
            cmd_valid = ($urandom_range(0, 99) < 80);
            rsp_ready = ($urandom_range(0, 99) < 70);
            cmd_data  = 8'($urandom_range(0, 20));
            if (r < 45)      cmd_op = 2'd1;
            else if (r < 70) cmd_op = 2'd0;
            else if (r < 96) cmd_op = 2'd2;
            else             cmd_op = 2'd3;
        end
        @(posedge clk);
        #1;
        rst       = 0;
        cmd_valid = 0;
        rsp_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
